// File: rtl/hcsr04_if.sv
// -----------------------------------------------------------------------------
// hcsr04_if
// Trig/echo link between an ultrasonic ranging controller (master) and the
// HC-SR04 responder/emulator (slave), plus the emulator's target settings
// and status pulses.
//
//   trig         master -> slave  trigger pulse (asynchronous to the slave)
//   distance_cm  master -> slave  emulated target distance in cm
//   no_object    master -> slave  1 = emulate "no echo return"
//   echo         slave -> master  echo pulse, width encodes distance
//   busy         slave -> master  responder is mid-measurement
//   trig_short   slave -> master  one-clock pulse: trigger too short
//   done         slave -> master  one-clock pulse on the echo falling cycle
// -----------------------------------------------------------------------------
interface hcsr04_if;
    logic        trig;
    logic [15:0] distance_cm;
    logic        no_object;
    logic        echo;
    logic        busy;
    logic        trig_short;
    logic        done;

    modport master (
        output trig,
        output distance_cm,
        output no_object,
        input  echo,
        input  busy,
        input  trig_short,
        input  done
    );

    modport slave (
        input  trig,
        input  distance_cm,
        input  no_object,
        output echo,
        output busy,
        output trig_short,
        output done
    );
endinterface

// File: rtl/hcsr04_responder.sv
// -----------------------------------------------------------------------------
// hcsr04_responder
// Emulates the responder end of the HC-SR04 trig/echo ranging protocol.
// A trigger pulse is synchronised and width-qualified; after a fixed burst
// delay an echo pulse is driven whose width encodes the programmed distance.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   hcsr04_if.slave: trig, distance_cm, no_object in;
//         echo, busy, trig_short, done out (all registered)
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a rising edge on the synchronised trigger
// TRIG_HI | trigger high, measuring its width (saturating)
// BURST   | emulated ultrasonic burst delay before echo rises
// ECHO    | echo high for the latched echo length
// HOLDOFF | dead time after echo fall; triggers ignored
// -----------------------------------------------------------------------------
module hcsr04_responder #(
    parameter int CLK_FREQ        = 12000000,
    parameter int TICKS_PER_CM    = 696,
    parameter int MIN_TRIG_CYCLES = 120,
    parameter int BURST_CYCLES    = 2400,
    parameter int MAX_CM          = 400,
    parameter int TIMEOUT_CYCLES  = 456000,
    parameter int HOLDOFF_CYCLES  = 12000
) (
    input  logic    clk,
    input  logic    rst,
    hcsr04_if.slave bus
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clock frequency is documentation only; all timing is given in cycles.
    localparam int clk_freq_unused = CLK_FREQ;

    localparam int PROD_MAX = MAX_CM * TICKS_PER_CM;
    localparam int CNT_MAX  = max2(max2(TIMEOUT_CYCLES, PROD_MAX),
                                   max2(BURST_CYCLES, HOLDOFF_CYCLES));
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int LEN_W    = $clog2(MIN_TRIG_CYCLES + 1);
    localparam int DIST_W   = $clog2(MAX_CM + 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO,
        HOLDOFF
    } state_t;

    state_t            state, state_nx;
    logic              trig_m, trig_s, trig_q;
    logic              trig_rise;
    logic [LEN_W-1:0]  trig_len, trig_len_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [15:0]       dist_l, dist_l_nx;
    logic              nobj_l, nobj_l_nx;
    logic [DIST_W-1:0] dist_c;
    logic [CNT_W-1:0]  echo_len;
    logic              short_c, done_c;
    logic              short_pend, done_pend;
    logic              echo_r, busy_r, short_r, done_r;

    // Two-flop synchroniser plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_m <= 1'b0;
            trig_s <= 1'b0;
            trig_q <= 1'b0;
        end else begin
            trig_m <= bus.trig;
            trig_s <= trig_m;
            trig_q <= trig_s;
        end
    end

    assign trig_rise = trig_s & ~trig_q;

    // Echo length from the latched target. The multiply only ever sees a
    // distance already clamped to MAX_CM, so it fits the phase counter.
    always_comb begin
        dist_c   = DIST_W'(dist_l);
        echo_len = CNT_W'(TIMEOUT_CYCLES);
        if (nobj_l || (dist_l > 16'(MAX_CM))) begin
            echo_len = CNT_W'(TIMEOUT_CYCLES);
        end else if (dist_l == 16'd0) begin
            echo_len = CNT_W'(1);
        end else begin
            echo_len = CNT_W'(dist_c) * CNT_W'(TICKS_PER_CM);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            trig_len <= '0;
            cnt      <= '0;
            dist_l   <= '0;
            nobj_l   <= 1'b0;
        end else begin
            state    <= state_nx;
            trig_len <= trig_len_nx;
            cnt      <= cnt_nx;
            dist_l   <= dist_l_nx;
            nobj_l   <= nobj_l_nx;
        end
    end

    // Phase timers are down-counters loaded with (length - 1) on entry and
    // terminating at zero.
    always_comb begin
        state_nx    = state;
        trig_len_nx = trig_len;
        cnt_nx      = cnt;
        dist_l_nx   = dist_l;
        nobj_l_nx   = nobj_l;
        short_c     = 1'b0;
        done_c      = 1'b0;

        case (state)
            IDLE: begin
                if (trig_rise) begin
                    state_nx    = TRIG_HI;
                    trig_len_nx = LEN_W'(1);
                end
            end

            TRIG_HI: begin
                if (trig_s) begin
                    if (trig_len < LEN_W'(MIN_TRIG_CYCLES)) begin
                        trig_len_nx = trig_len + LEN_W'(1);
                    end
                end else if (trig_len >= LEN_W'(MIN_TRIG_CYCLES)) begin
                    dist_l_nx = bus.distance_cm;
                    nobj_l_nx = bus.no_object;
                    cnt_nx    = CNT_W'(BURST_CYCLES - 1);
                    state_nx  = BURST;
                end else begin
                    short_c  = 1'b1;
                    state_nx = IDLE;
                end
            end

            BURST: begin
                if (cnt == '0) begin
                    cnt_nx   = echo_len - CNT_W'(1);
                    state_nx = ECHO;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end

            ECHO: begin
                if (cnt == '0) begin
                    done_c   = 1'b1;
                    cnt_nx   = CNT_W'(HOLDOFF_CYCLES - 1);
                    state_nx = HOLDOFF;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end

            HOLDOFF: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs are registered from the state register; the event pulses get
    // one extra stage so they line up with the echo/busy levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            short_pend <= 1'b0;
            done_pend  <= 1'b0;
            echo_r     <= 1'b0;
            busy_r     <= 1'b0;
            short_r    <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            short_pend <= short_c;
            done_pend  <= done_c;
            echo_r     <= (state == ECHO);
            busy_r     <= (state != IDLE);
            short_r    <= short_pend;
            done_r     <= done_pend;
        end
    end

    assign bus.echo       = echo_r;
    assign bus.busy       = busy_r;
    assign bus.trig_short = short_r;
    assign bus.done       = done_r;

endmodule
